freq_uart_reporter: RTL
=======================

FREQ_UART_REPORTER -- requirements
Module: freq_uart_reporter

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 40_000_000, system clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 115_200, UART bit rate.
REQ-003 SHALL provide parameter BLANK_LZ, default 1, 1 = suppress leading zero digits.
REQ-004 SHALL provide port clk  input  1  system clock; all logic on its rising edge; the block has only this one clock.
REQ-005 SHALL provide port res  input  1  reset; synchronous and active-high.
REQ-006 SHALL provide port bcd_in  input  36  nine latched BCD digits; digit k at [4k+3:4k]; digit 0 = least significant.
REQ-007 SHALL provide port upd  input  1  one-cycle strobe, synchronous to clk: a new measurement is valid on bcd_in.
REQ-008 SHALL provide port tx  output  1  UART 8N1 serial line; idles high.
REQ-009 SHALL provide port busy  output  1  high while a report frame is in progress.
REQ-010 SHALL provide port ovr  output  1  one-cycle pulse when an upd is dropped.

Function
REQ-011 SHALL use a bit period of DIV = CLK_HZ/BAUD clocks (integer division, truncated); every start, data and stop bit holds for exactly DIV cycles.
REQ-012 SHALL frame each character as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); there SHALL be no idle gap between characters of one frame.
REQ-013 SHALL, on upd=1 while busy=0, snapshot all 36 bits of bcd_in into an internal register; later changes on bcd_in SHALL NOT affect the frame.
REQ-014 SHALL transmit as its frame: the digits from most to least significant, then 0x0D, then 0x0A.
REQ-015 SHALL, when BLANK_LZ=1, skip digits above the highest nonzero digit; digit 0 SHALL always be sent, so an all-zero value reports a single '0'.
REQ-016 SHALL, when BLANK_LZ=0, send all nine digits.
REQ-017 SHALL encode digit values 0-9 as ASCII 0x30+d, and values 10-15 as '?' (0x3F); a nonzero non-BCD value counts as nonzero for blanking.
REQ-018 SHALL select the first digit index combinationally at snapshot time, adding no extra latency.
REQ-019 SHALL assert busy and drive the start bit low on the clock edge after the cycle in which upd was sampled.
REQ-020 SHALL implement the states IDLE -> START -> DATA(8 bits) -> STOP -> START for the next character, or IDLE after the stop bit of 0x0A.
REQ-021 SHALL deassert busy in the cycle after the final stop bit completes; frame length in cycles = 10*DIV*(characters).
REQ-022 SHALL, on upd=1 while busy=1, ignore the strobe, pulse ovr for exactly that following cycle, and leave the current frame unchanged.
REQ-023 SHALL accept an upd arriving in the first cycle where busy=0.
REQ-024 SHALL use a baud counter width of clog2(DIV), a 4-bit character index, and a 3-bit bit index; no counter SHALL wrap within a frame.

Reset
REQ-025 SHALL, when res=1, drive these values from the next edge onward: tx=1, busy=0, ovr=0, state=IDLE, counters=0, snapshot=0.
REQ-026 SHALL let res abort a frame mid-character; no residual bits SHALL be sent.
REQ-027 SHALL have res take priority over a simultaneous upd, so the upd is lost and ovr is not pulsed.

Verification (CLK_HZ=80, BAUD=10, DIV=8)
REQ-028 SHALL verify: BLANK_LZ=1, bcd_in=0x000012345, upd pulse -> tx carries 0x31 0x32 0x33 0x34 0x35 0x0D 0x0A; busy is high for 560 cycles; start bit falls 1 cycle after upd.
REQ-029 SHALL verify: bcd_in=0, upd -> "0\r\n", busy is high for 240 cycles.
REQ-030 SHALL verify: BLANK_LZ=0, bcd_in=0x000000007 -> "000000007\r\n" (11 characters, 880 cycles).
REQ-031 SHALL verify: bcd_in=0x000000A05 -> "?05\r\n"; and with bcd_in changed mid-frame, the output is unchanged.
REQ-032 SHALL verify: a second upd 100 cycles into a frame -> ovr high for exactly 1 cycle, the frame is intact, and no second frame follows.
REQ-033 SHALL verify: res asserted during the 3rd data bit -> tx=1 and busy=0 from the next cycle; a following upd produces a complete, correct frame.

Source files
------------

// File: rtl/freq_uart_reporter.sv
// freq_uart_reporter: sends a latched 9-digit BCD value as ASCII digits plus CR LF over a UART 8N1 line
module freq_uart_reporter #(
    parameter int CLK_HZ   = 40_000_000,
    parameter int BAUD     = 115_200,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        res,
    input  logic [35:0] bcd_in,
    input  logic        upd,
    output logic        tx,
    output logic        busy,
    output logic        ovr
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    chr_idx, first_idx, lead, dsel, dig;
    logic [2:0]    bit_idx;
    logic [35:0]   snap;
    logic [7:0]    chr;
    logic          bit_end, last;

    always_comb begin
        lead = 4'd0;
        for (int i = 1; i < 9; i++)
            if (bcd_in[4*i +: 4] != 4'd0) lead = 4'(i);
    end

    // chr_idx counts characters sent: digits first_idx down to 0, then CR, then LF
    assign dsel    = first_idx - chr_idx;
    assign last    = chr_idx == first_idx + 4'd2;
    assign bit_end = baud_cnt == CW'(DIV - 1);

    always_comb begin
        dig = 4'd0;
        for (int i = 0; i < 9; i++)
            if (dsel == 4'(i)) dig = snap[4*i +: 4];
    end

    assign chr = chr_idx == first_idx + 4'd1 ? 8'h0D :
                 last                        ? 8'h0A :
                 dig > 4'd9                  ? 8'h3F : {4'h3, dig};

    always_ff @(posedge clk)
        if (res) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = upd ? START : IDLE;
            START:   state_nxt = bit_end ? DATA : START;
            DATA:    state_nxt = bit_end && bit_idx == 3'd7 ? STOP : DATA;
            STOP:    state_nxt = !bit_end ? STOP : last ? IDLE : START;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx   = state == START ? 1'b0 : state == DATA ? chr[bit_idx] : 1'b1;
        busy = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            baud_cnt  <= '0;
            chr_idx   <= '0;
            bit_idx   <= '0;
            first_idx <= '0;
            snap      <= '0;
            ovr       <= 1'b0;
        end else begin
            ovr      <= upd && state != IDLE;
            baud_cnt <= state == IDLE || bit_end ? '0 : baud_cnt + 1'b1;
            if (state == IDLE && upd) begin
                snap      <= bcd_in;
                first_idx <= BLANK_LZ != 0 ? lead : 4'd8;
                chr_idx   <= '0;
                bit_idx   <= '0;
            end
            if (state == DATA && bit_end && bit_idx != 3'd7) bit_idx <= bit_idx + 1'b1;
            if (state == STOP) bit_idx <= '0;
            if (state == STOP && bit_end && !last) chr_idx <= chr_idx + 1'b1;
        end
    end
endmodule
